iq_skew_dly: RTL



---
 rtl/iq_skew_dly.sv | 111 +++++++++++
 1 files changed

// File: rtl/iq_skew_dly.sv
// iq_skew_dly: runtime-selectable relative I/Q symbol delay with common delay removed, optional I/Q swap.
// Latency: 1 cycle from a qualifying i_valid to o_valid; delay is counted in accepted samples, not cycles.
// Backpressure: none; sustains one sample per cycle, and a delay change flushes the line and refills it.
module iq_skew_dly #(
  parameter int  DATA_WIDTH = 6,
  parameter int  MAX_DLY    = 3,
  localparam int DLY_W      = $clog2(MAX_DLY + 1)
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic [DATA_WIDTH-1:0] i_i,
  input  logic [DATA_WIDTH-1:0] i_q,
  input  logic                  i_valid,
  input  logic [DLY_W-1:0]      i_i_dly,
  input  logic [DLY_W-1:0]      i_q_dly,
  input  logic                  i_swap,
  output logic [DATA_WIDTH-1:0] o_i,
  output logic [DATA_WIDTH-1:0] o_q,
  output logic                  o_valid,
  output logic                  o_busy
);

  localparam logic [DLY_W-1:0] MAX_D = DLY_W'(MAX_DLY);

  // Normalised delays: clamped request, common part removed, N = relative delay
  logic [DLY_W-1:0] d_i, d_q, d_min, rel_i, rel_q, n_dly;
  // Last applied configuration and samples accepted since the last flush (saturating at N)
  logic [DLY_W-1:0] cfg_i, cfg_q, fill, fill_nxt;
  logic             change, accept, qualify;

  // Taps 1..MAX_DLY of each delay line; tap 0 is the live input
  logic [DATA_WIDTH-1:0] sr_i [MAX_DLY];
  logic [DATA_WIDTH-1:0] sr_q [MAX_DLY];
  logic [DATA_WIDTH-1:0] sel_i, sel_q;

  // Clamp requests and strip the common delay so at most one channel is held back.
  always_comb begin
    d_i   = (i_i_dly > MAX_D) ? MAX_D : i_i_dly;
    d_q   = (i_q_dly > MAX_D) ? MAX_D : i_q_dly;
    d_min = (d_i < d_q) ? d_i : d_q;
    rel_i = d_i - d_min;
    rel_q = d_q - d_min;
    n_dly = (rel_i > rel_q) ? rel_i : rel_q;
  end

  // A new delay pair flushes the line and discards this cycle's sample; a sample
  // produces output only once N earlier samples are in the line.
  always_comb begin
    change   = (d_i != cfg_i) || (d_q != cfg_q);
    accept   = i_valid && !change;
    qualify  = accept && (fill >= n_dly);
    fill_nxt = (accept && (fill < n_dly)) ? fill + DLY_W'(1) : fill;
  end

  // Pick the tap matching each channel's relative delay.
  always_comb begin
    sel_i = i_i;
    sel_q = i_q;
    for (int k = 1; k <= MAX_DLY; k++) begin
      if (rel_i == DLY_W'(k)) sel_i = sr_i[k-1];
      if (rel_q == DLY_W'(k)) sel_q = sr_q[k-1];
    end
  end

  // Delay line advances on accepted samples only; cleared on reset or delay change.
  always_ff @(posedge i_clk) begin
    if (i_reset || change) begin
      for (int k = 0; k < MAX_DLY; k++) begin
        sr_i[k] <= '0;
        sr_q[k] <= '0;
      end
    end else if (i_valid) begin
      sr_i[0] <= i_i;
      sr_q[0] <= i_q;
      for (int k = 1; k < MAX_DLY; k++) begin
        sr_i[k] <= sr_i[k-1];
        sr_q[k] <= sr_q[k-1];
      end
    end
  end

  // Configuration tracking, fill counting and the registered output stage.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      cfg_i   <= '0;
      cfg_q   <= '0;
      fill    <= '0;
      o_i     <= '0;
      o_q     <= '0;
      o_valid <= 1'b0;
      o_busy  <= 1'b0;
    end else begin
      cfg_i   <= d_i;
      cfg_q   <= d_q;
      o_valid <= qualify;
      if (change) begin
        fill   <= '0;
        o_busy <= (n_dly != '0);
      end else begin
        fill   <= fill_nxt;
        o_busy <= (fill_nxt < n_dly);
      end
      // Swap is applied at output time only, so toggling it never disturbs the line.
      if (qualify) begin
        o_i <= i_swap ? sel_q : sel_i;
        o_q <= i_swap ? sel_i : sel_q;
      end
    end
  end

endmodule
